// File: rtl/key_entry.sv
// Debounced keypad entry: frame-based key qualification feeding a 4-digit BCD
// entry buffer with '*' (clear) and '#' (commit) handling.
module key_entry #(
    parameter int DEB_FRAMES = 4,
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_inp,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic [15:0] buf_bcd,
    output logic [2:0]  buf_len,
    output logic        entry_valid,
    output logic [15:0] entry_value,
    output logic [2:0]  entry_len,
    output logic        err
);

    localparam logic [3:0] C_STAR  = 4'd10;
    localparam logic [3:0] C_HASH  = 4'd11;
    localparam logic [3:0] C_NONE  = 4'd12;
    localparam logic [3:0] C_CONF  = 4'd13;
    localparam logic [3:0] DEB_CNT = 4'(DEB_FRAMES);
    localparam logic [2:0] MAX_LEN = 3'(MAX_DIGITS);

    typedef enum logic {S_IDLE, S_HELD} state_t;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    // Fold one scanner sample into the running frame code.
    function automatic logic [3:0] merge_code(input logic [3:0] acc, input logic [3:0] k);
        if (k > C_HASH)   return acc;
        if (acc == C_NONE) return k;
        if (acc == k)      return acc;
        return C_CONF;
    endfunction

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [3:0]  r_acc_p0;
    logic [3:0]  r_prev;
    logic [3:0]  r_stable;
    logic        r_key_event;
    logic [3:0]  r_key_code;
    logic [15:0] r_buf_bcd;
    logic [2:0]  r_buf_len;
    logic        r_entry_valid;
    logic [15:0] r_entry_value;
    logic [2:0]  r_entry_len;
    logic        r_err;

    logic [3:0]  w_base;
    logic [3:0]  w_code;
    logic [3:0]  w_stable;
    logic        w_frame_end;
    logic        w_qual;
    logic        w_press;
    logic        w_release;

    // Stage p0: frame code accumulation and debounce qualification
    always_comb begin
        w_base      = (r_cnt == 2'd0) ? C_NONE : r_acc_p0;
        w_code      = merge_code(w_base, key_inp);
        w_frame_end = (r_cnt == 2'd3);
        w_stable    = (w_code == r_prev) ? sat_inc(r_stable) : 4'd1;
        w_qual      = (w_stable >= DEB_CNT);
        w_press     = w_frame_end && (r_state == S_IDLE) && (w_code <= C_HASH) && w_qual;
        w_release   = w_frame_end && (r_state == S_HELD) && (w_code == C_NONE) && w_qual;
    end

    // Stage p1: registered press FSM, event outputs and entry buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 2'd0;
            r_acc_p0      <= C_NONE;
            r_prev        <= C_NONE;
            r_stable      <= 4'd0;
            r_key_event   <= 1'b0;
            r_key_code    <= C_NONE;
            r_buf_bcd     <= 16'h0000;
            r_buf_len     <= 3'd0;
            r_entry_valid <= 1'b0;
            r_entry_value <= 16'h0000;
            r_entry_len   <= 3'd0;
            r_err         <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + 2'd1;
            r_acc_p0      <= w_code;
            r_key_event   <= 1'b0;
            r_entry_valid <= 1'b0;
            r_err         <= 1'b0;

            if (w_frame_end) begin
                r_prev   <= w_code;
                r_stable <= w_stable;
            end

            case (r_state)
                S_IDLE: if (w_press) r_state <= S_HELD;
                S_HELD: if (w_release) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_press) begin
                r_key_event <= 1'b1;
                r_key_code  <= w_code;
                if (w_code == C_STAR) begin
                    r_buf_bcd <= 16'h0000;
                    r_buf_len <= 3'd0;
                end else if (w_code == C_HASH) begin
                    if (r_buf_len != 3'd0) begin
                        r_entry_value <= r_buf_bcd;
                        r_entry_len   <= r_buf_len;
                        r_entry_valid <= 1'b1;
                        r_buf_bcd     <= 16'h0000;
                        r_buf_len     <= 3'd0;
                    end else begin
                        r_err <= 1'b1;
                    end
                end else if (r_buf_len < MAX_LEN) begin
                    r_buf_bcd <= {r_buf_bcd[11:0], w_code};
                    r_buf_len <= r_buf_len + 3'd1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign key_event   = r_key_event;
    assign key_code    = r_key_code;
    assign buf_bcd     = r_buf_bcd;
    assign buf_len     = r_buf_len;
    assign entry_valid = r_entry_valid;
    assign entry_value = r_entry_value;
    assign entry_len   = r_entry_len;
    assign err         = r_err;

endmodule

// File: tb/tb_key_entry.sv
// Directed bench for key_entry with DEB_FRAMES=2: press/release debounce,
// digit entry, commit, overflow, clear, glitch rejection and mid-press reset.
module tb_key_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key_inp;
    logic        key_event;
    logic [3:0]  key_code;
    logic [15:0] buf_bcd;
    logic [2:0]  buf_len;
    logic        entry_valid;
    logic [15:0] entry_value;
    logic [2:0]  entry_len;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int ev_cnt = 0;
    int err_cnt = 0;
    int val_cnt = 0;
    int bad_cnt = 0;
    int e0, r0, v0;

    key_entry #(.DEB_FRAMES(2), .MAX_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .key_inp(key_inp),
        .key_event(key_event), .key_code(key_code),
        .buf_bcd(buf_bcd), .buf_len(buf_len),
        .entry_valid(entry_valid), .entry_value(entry_value),
        .entry_len(entry_len), .err(err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; flags entry_valid/err outside key_event.
    always @(negedge clk) begin
        if (key_event)   ev_cnt++;
        if (err)         err_cnt++;
        if (entry_valid) val_cnt++;
        if ((entry_valid || err) && !key_event) bad_cnt++;
        if (entry_valid && err) bad_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 4-cycle frame: code a in slot 0, code b in slot 2, none elsewhere.
    task automatic frame(input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            key_inp = (i == 0) ? a : ((i == 2) ? b : 4'd12);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        for (int i = 0; i < n; i++) frame(c, 4'd12);
    endtask

    task automatic press(input logic [3:0] c);
        hold(c, 3);
        hold(4'd12, 3);
    endtask

    initial begin
        rst = 1'b1;
        key_inp = 4'd12;
        repeat (2) @(posedge clk);
        #1;
        check("rst_key_event", key_event, 0);
        check("rst_key_code", key_code, 12);
        check("rst_buf_bcd", buf_bcd, 0);
        check("rst_buf_len", buf_len, 0);
        check("rst_entry_valid", entry_valid, 0);
        check("rst_entry_value", entry_value, 0);
        check("rst_entry_len", entry_len, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        // Long hold of key 5 then release
        e0 = ev_cnt;
        frame(4'd5, 4'd12);
        check("hold5_f1_noevent", key_event, 0);
        frame(4'd5, 4'd12);
        check("hold5_f2_event", key_event, 1);
        check("hold5_f2_buf_len", buf_len, 1);
        hold(4'd5, 10);
        hold(4'd12, 3);
        check("hold5_events", ev_cnt - e0, 1);
        check("hold5_code", key_code, 5);
        check("hold5_buf", buf_bcd, 16'h0005);
        check("hold5_len", buf_len, 1);

        r0 = err_cnt;
        press(4'd10);
        check("star_len", buf_len, 0);
        check("star_noerr", err_cnt - r0, 0);

        // Commit 1234
        v0 = val_cnt;
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        check("e1234_buf", buf_bcd, 16'h1234);
        check("e1234_len_pre", buf_len, 4);
        press(4'd11);
        check("e1234_valid_cnt", val_cnt - v0, 1);
        check("e1234_value", entry_value, 16'h1234);
        check("e1234_elen", entry_len, 4);
        check("e1234_buf_len", buf_len, 0);
        check("e1234_buf_clr", buf_bcd, 0);

        // Overflow on fifth digit
        r0 = err_cnt;
        e0 = ev_cnt;
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        check("ovf_noerr_4", err_cnt - r0, 0);
        press(4'd5);
        check("ovf_err", err_cnt - r0, 1);
        check("ovf_events", ev_cnt - e0, 5);
        check("ovf_buf", buf_bcd, 16'h9876);
        check("ovf_len", buf_len, 4);
        press(4'd10);

        // Clear then empty commit
        r0 = err_cnt;
        v0 = val_cnt;
        press(4'd4); press(4'd2);
        check("clr_buf_pre", buf_bcd, 16'h0042);
        press(4'd10);
        check("clr_buf", buf_bcd, 0);
        check("clr_len", buf_len, 0);
        press(4'd11);
        check("empty_hash_err", err_cnt - r0, 1);
        check("empty_hash_novalid", val_cnt - v0, 0);
        check("empty_hash_value", entry_value, 16'h1234);
        check("empty_hash_elen", entry_len, 4);

        // One-frame glitch and conflicting frames
        e0 = ev_cnt;
        hold(4'd12, 2);
        hold(4'd7, 1);
        hold(4'd12, 3);
        check("glitch_noevent", ev_cnt - e0, 0);
        for (int i = 0; i < 3; i++) frame(4'd5, 4'd6);
        hold(4'd12, 3);
        check("conflict_noevent", ev_cnt - e0, 0);
        check("glitch_len", buf_len, 0);

        // Reset while key 3 held with two digits buffered
        press(4'd1);
        hold(4'd3, 2);
        check("mid_buf", buf_bcd, 16'h0013);
        check("mid_len", buf_len, 2);
        rst = 1'b1;
        key_inp = 4'd3;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_buf", buf_bcd, 0);
        check("mid_rst_len", buf_len, 0);
        check("mid_rst_code", key_code, 12);
        check("mid_rst_value", entry_value, 0);
        check("mid_rst_elen", entry_len, 0);
        frame(4'd3, 4'd12);
        check("requal_f1_noevent", key_event, 0);
        frame(4'd3, 4'd12);
        check("requal_f2_event", key_event, 1);
        check("requal_buf", buf_bcd, 16'h0003);
        check("requal_len", buf_len, 1);
        hold(4'd12, 3);

        check("pulse_exclusive", bad_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
